// File: rtl/wb_master.sv
// Pipelined Wishbone B4 initiator: valid/ready requests in, bus cycles out, registered responses back.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic {Idle, Active} state_e;

    localparam logic [4:0] MaxOut = 5'(MAX_OUTSTANDING);

    state_e      state_q;
    logic [31:0] adr_q, dat_q, rspData_q;
    logic [3:0]  sel_q, cnt_q, cnt_d;
    logic        we_q, stb_q, stb_d, cyc_q, rspValid_q;
    logic        issue, countedAck, accept, timeout;

    assign issue       = stb_q && !wb_stall_i;
    assign countedAck  = wb_ack_i && (cnt_q != 4'd0);
    // The pending strobe reserves a slot so an issue can never overrun the limit.
    assign req_ready_o = (!stb_q || !wb_stall_i) &&
                         (({1'b0, cnt_q} + {4'b0000, stb_q}) < MaxOut);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        stb_d = stb_q;
        if (accept) begin
            stb_d = 1'b1;
        end else if (issue) begin
            stb_d = 1'b0;
        end
        cnt_d = cnt_q + {3'b000, issue} - {3'b000, countedAck};
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    logic [7:0] wd_q;
    logic       rspErr_q;

    // A late ack in the limit cycle still wins over the timeout.
    assign timeout = (wd_q == TimeoutLimit) && !countedAck && (cnt_q != 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wd_q     <= 8'd0;
            rspErr_q <= 1'b0;
        end else begin
            rspErr_q <= timeout;
            if (countedAck || (cnt_q == 4'd0) || timeout) begin
                wd_q <= 8'd0;
            end else begin
                wd_q <= wd_q + 8'd1;
            end
        end
    end

    assign rsp_err_o = rspErr_q;
`else
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            we_q       <= 1'b0;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
            cnt_q      <= 4'd0;
            rspValid_q <= 1'b0;
            rspData_q  <= 32'd0;
        end else begin
            rspValid_q <= countedAck;
            if (countedAck) begin
                rspData_q <= wb_dat_i;
            end
            if (timeout) begin
                state_q <= Idle;
                stb_q   <= 1'b0;
                cyc_q   <= 1'b0;
                cnt_q   <= 4'd0;
            end else begin
                cnt_q <= cnt_d;
                stb_q <= stb_d;
                if (accept) begin
                    adr_q <= req_addr_i;
                    dat_q <= req_data_i;
                    sel_q <= req_sel_i;
                    we_q  <= req_we_i;
                end
                case (state_q)
                    Idle: begin
                        if (accept) begin
                            state_q <= Active;
                            cyc_q   <= 1'b1;
                        end
                    end
                    Active: begin
                        if ((cnt_d == 4'd0) && !stb_d) begin
                            state_q <= Idle;
                            cyc_q   <= 1'b0;
                        end
                    end
                    default: state_q <= Idle;
                endcase
            end
        end
    end

    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_stb_o    = stb_q;
    assign wb_cyc_o    = cyc_q;
    assign busy_o      = cyc_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;

endmodule
